mod_addsub_serial: RTL and testbench

- Parametrised, limb-serial modular adder/subtractor; next generation of the single-field ALU test path.
- Computes (opa ± opb) mod p for a run-time-selected field: Curve25519 prime or parameter MOD_ALT.
- Datapath is LIMB bits wide; full-width result assembled over 2·N/LIMB cycles.
- Sits beside the multiplier/inverter in the field ALU and shares its run/done/bad_op handshake.

---
 rtl/mod_addsub_serial.sv | 219 +++++++++++++++++++++
 tb/tb_mod_addsub_serial.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_serial.sv
// -----------------------------------------------------------------------------
// mod_addsub_serial
//
// Limb-serial modular adder/subtractor for the field ALU. It computes
// (opa + opb) mod p or (opa - opb) mod p. The modulus is chosen per operation:
// the Curve25519 prime 2^255-19 when fld_25519=1, or MOD_ALT (P-256 by
// default) when fld_25519=0. One LIMB-wide adder is shared by two passes of
// L = N/LIMB cycles each, and limbs are processed LSB first:
//   P1 : s = a +/- b                 (the final carry/borrow is kept in c1)
//   P2 : t = s - p (add), s + p (sub) (the carry of the sub pass is dropped)
// The correction choice between s and t is made as the last P2 limb retires,
// so res and done change on the same edge.
//
// Parameters:
//   N       operand/result width; N % LIMB must be 0 and N >= 256
//   LIMB    limb width handled per cycle
//   MOD_ALT modulus used when fld_25519 = 0 (zero-extended to N)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   run        start request, accepted only in IDLE
//   op_sub     0 = add, 1 = subtract (latched on accept)
//   fld_25519  1 = 2^255-19, 0 = MOD_ALT (latched on accept)
//   opa, opb   operands (latched on accept)
//   res        registered result, held until the next good completion
//   busy       high from the cycle after accept through the FIN cycle
//   done       one-cycle completion pulse, coincides with FIN
//   bad_op     an operand was >= p for the last accepted operation
//
// Timing, with T the accepting edge: CHK in cycle T+1, P1 in T+2..T+L+1,
// P2 in T+L+2..T+2L+1, and FIN/done in T+2L+2. A bad operand skips both
// passes, so done comes in T+2.
// -----------------------------------------------------------------------------
module mod_addsub_serial #(
   parameter int          N       = 256,
   parameter int          LIMB    = 64,
   parameter logic [N-1:0] MOD_ALT =
      N'(256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         run,
   input  logic         op_sub,
   input  logic         fld_25519,
   input  logic [N-1:0] opa,
   input  logic [N-1:0] opb,
   output logic [N-1:0] res,
   output logic         busy,
   output logic         done,
   output logic         bad_op
);

   localparam int L  = N / LIMB;
   localparam int CW = (L > 1) ? $clog2(L) : 1;
   localparam logic [CW-1:0] LAST_LIMB = CW'(L - 1);

   // 2^255 - 19, zero-extended to the datapath width.
   localparam logic [N-1:0] P_25519 =
      N'(256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHK,
      S_P1,
      S_P2,
      S_FIN
   } state_t;

   state_t         state;
   logic [N-1:0]   a_q;      // operand A, shifted down one limb per P1 cycle
   logic [N-1:0]   b_q;      // operand B, shifted down one limb per P1 cycle
   logic [N-1:0]   p_q;      // selected modulus, rotated one limb per P2 cycle
   logic [N-1:0]   s_q;      // first-pass result, rotated during P2
   logic [N-1:0]   t_q;      // second-pass result, assembled during P2
   logic           sub_q;
   logic           carry_q;  // limb-to-limb carry of the running pass
   logic           c1_q;     // true carry (add) or borrow (sub) out of P1
   logic [CW-1:0]  cnt_q;

   logic [LIMB-1:0] in_x;
   logic [LIMB-1:0] in_y;
   logic            inv_y;
   logic [LIMB:0]   limb_sum;
   logic            last_limb;
   logic            take_t;
   logic            op_bad;

   // Insert a limb at the top of a word, dropping its low limb. The
   // concatenate-then-slice form stays legal when N == LIMB.
   function automatic logic [N-1:0] shift_in(input logic [N-1:0]    v,
                                             input logic [LIMB-1:0] l);
      logic [N+LIMB-1:0] w;
      w = {l, v};
      return w[N+LIMB-1:LIMB];
   endfunction

   // Shared limb adder. Subtraction is done as x + ~y + 1: the pass's
   // initial carry is set to the invert flag, so carry-out = 1 means
   // "no borrow".
   //   P1: x = a, y = b, inverted for subtract.
   //   P2: x = s, y = p, inverted for add (s - p), straight for sub (s + p).
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      in_x  = s_q[LIMB-1:0];
      in_y  = p_q[LIMB-1:0];
      inv_y = ~sub_q;
      if (state == S_P1) begin
         in_x  = a_q[LIMB-1:0];
         in_y  = b_q[LIMB-1:0];
         inv_y = sub_q;
      end
      limb_sum = {1'b0, in_x} + {1'b0, in_y ^ {LIMB{inv_y}}} + {{LIMB{1'b0}}, carry_q};
   end

   assign last_limb = (cnt_q == LAST_LIMB);
   assign op_bad    = (a_q >= p_q) || (b_q >= p_q);

   // Correction choice on the final P2 limb. For an add, "no borrow from
   // s - p" is the adder's carry-out; for a subtract only the P1 borrow
   // matters, because s + p wraps mod 2^N.
   assign take_t = c1_q | (~sub_q & limb_sum[LIMB]);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the wide operand and pass registers are cleared along with
         // the control state, so an aborted operation leaves nothing behind.
         state   <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         p_q     <= '0;
         s_q     <= '0;
         t_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         c1_q    <= 1'b0;
         cnt_q   <= '0;
         res     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bad_op  <= 1'b0;
      end else begin
         // NOTE: all state here uses non-blocking assignments, so every
         // right-hand side sees the values from before this edge.
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (run) begin
                  a_q    <= opa;
                  b_q    <= opb;
                  sub_q  <= op_sub;
                  p_q    <= fld_25519 ? P_25519 : MOD_ALT;
                  bad_op <= 1'b0;
                  busy   <= 1'b1;
                  state  <= S_CHK;
               end
            end

            S_CHK: begin
               cnt_q   <= '0;
               carry_q <= sub_q;
               if (op_bad) begin
                  // Skip both passes; res keeps its previous value.
                  bad_op <= 1'b1;
                  done   <= 1'b1;
                  state  <= S_FIN;
               end else begin
                  state  <= S_P1;
               end
            end

            S_P1: begin
               a_q     <= shift_in(a_q, {LIMB{1'b0}});
               b_q     <= shift_in(b_q, {LIMB{1'b0}});
               s_q     <= shift_in(s_q, limb_sum[LIMB-1:0]);
               carry_q <= limb_sum[LIMB];
               cnt_q   <= cnt_q + 1'b1;
               if (last_limb) begin
                  // Store a true borrow for subtract (carry-out inverted).
                  c1_q    <= sub_q ? ~limb_sum[LIMB] : limb_sum[LIMB];
                  carry_q <= ~sub_q;
                  cnt_q   <= '0;
                  state   <= S_P2;
               end
            end

            S_P2: begin
               // s and p are rotated, not shifted: after L cycles they are back
               // in their original alignment, so s is still whole for the
               // final choice.
               s_q     <= shift_in(s_q, s_q[LIMB-1:0]);
               p_q     <= shift_in(p_q, p_q[LIMB-1:0]);
               t_q     <= shift_in(t_q, limb_sum[LIMB-1:0]);
               carry_q <= limb_sum[LIMB];
               cnt_q   <= cnt_q + 1'b1;
               if (last_limb) begin
                  res   <= take_t ? shift_in(t_q, limb_sum[LIMB-1:0])
                                  : shift_in(s_q, s_q[LIMB-1:0]);
                  done  <= 1'b1;
                  cnt_q <= '0;
                  state <= S_FIN;
               end
            end

            S_FIN: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mod_addsub_serial.sv
// -----------------------------------------------------------------------------
// tb_mod_addsub_serial
//
// Bench for mod_addsub_serial with default parameters (N=256, LIMB=64). The
// expected results come from plain modular arithmetic on 258-bit values. The
// bench also checks the latency, the busy window, the hold and clear
// behaviour of bad_op and res, that run is ignored while busy, and an
// asynchronous reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_mod_addsub_serial;

   localparam int N = 256;
   localparam int L = 4;
   localparam logic [255:0] P25519 =
      256'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFED;
   localparam logic [255:0] P256 =
      256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

   logic         clk;
   logic         rst;
   logic         run;
   logic         op_sub;
   logic         fld_25519;
   logic [N-1:0] opa;
   logic [N-1:0] opb;
   logic [N-1:0] res;
   logic         busy;
   logic         done;
   logic         bad_op;

   int           n_checks;
   int           n_errors;
   logic [255:0] last_res;

   mod_addsub_serial dut (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .op_sub    (op_sub),
      .fld_25519 (fld_25519),
      .opa       (opa),
      .opb       (opb),
      .res       (res),
      .busy      (busy),
      .done      (done),
      .bad_op    (bad_op)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference model: modular add/sub with plain wide arithmetic.
   function automatic logic [255:0] model(input logic [255:0] a, input logic [255:0] b,
                                          input logic sub, input logic [255:0] p);
      logic [257:0] w;
      if (!sub) w = {2'b0, a} + {2'b0, b};
      else      w = {2'b0, a} + {2'b0, p} - {2'b0, b};
      if (w >= {2'b0, p}) w = w - {2'b0, p};
      return w[255:0];
   endfunction

   // Issue one operation and check its whole handshake. With disturb=1 the
   // bench toggles run and scrambles the inputs while the operation is busy.
   task automatic run_op(input string tag, input logic [255:0] a, input logic [255:0] b,
                         input logic sub, input logic fld, input bit disturb);
      logic [255:0] p;
      logic [255:0] exp_res;
      logic         exp_bad;
      int           exp_lat;
      int           n;
      bit           busy_ok;
      bit           seen;
      p       = fld ? P25519 : P256;
      exp_bad = (a >= p) || (b >= p);
      exp_res = exp_bad ? last_res : model(a, b, sub, p);
      exp_lat = exp_bad ? 2 : 2 + 2 * L;

      @(negedge clk);
      run = 1'b1; opa = a; opb = b; op_sub = sub; fld_25519 = fld;
      @(posedge clk);
      #1;
      run = 1'b0; opa = rnd256(); opb = rnd256(); op_sub = ~sub; fld_25519 = ~fld;

      busy_ok = 1'b1;
      seen    = 1'b0;
      n       = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (!busy) busy_ok = 1'b0;
         if (n == 1) check({tag, "/bad_clr_on_accept"}, {255'b0, bad_op}, 256'd0);
         if (disturb && n >= 2 && n <= 5) begin
            run = n[0]; opa = rnd256(); opb = rnd256(); op_sub = $urandom_range(0, 1);
         end
         if (disturb && n == 6) run = 1'b0;
         if (done) seen = 1'b1;
      end
      check({tag, "/latency"}, 256'(n), 256'(exp_lat));
      check({tag, "/res"}, res, exp_res);
      check({tag, "/bad_op"}, {255'b0, bad_op}, {255'b0, exp_bad});
      check({tag, "/busy_window"}, {255'b0, busy_ok}, 256'd1);
      @(negedge clk);
      check({tag, "/idle_after_fin"}, {254'b0, busy, done}, 256'd0);
      last_res = exp_res;
   endtask

   initial begin
      logic [255:0] a;
      logic [255:0] b;
      logic [255:0] p;
      bit           done_seen;
      n_checks  = 0;
      n_errors  = 0;
      last_res  = '0;
      rst       = 1'b0;
      run       = 1'b0;
      op_sub    = 1'b0;
      fld_25519 = 1'b1;
      opa       = '0;
      opb       = '0;
      repeat (3) @(negedge clk);
      check("reset/res", res, 256'd0);
      check("reset/flags", {253'b0, busy, done, bad_op}, 256'd0);
      rst = 1'b1;

      // Directed cases.
      run_op("add_5_7",        256'd5,      256'd7,      1'b0, 1'b1, 1'b0);
      run_op("add_wrap",       P25519 - 1,  256'd2,      1'b0, 1'b1, 1'b0);
      run_op("add_pm1_pm1",    P25519 - 1,  P25519 - 1,  1'b0, 1'b1, 1'b0);
      run_op("sub_3_5",        256'd3,      256'd5,      1'b1, 1'b1, 1'b0);
      run_op("sub_equal",      256'h1234,   256'h1234,   1'b1, 1'b1, 1'b0);
      run_op("alt_add_max",    P256 - 1,    P256 - 1,    1'b0, 1'b0, 1'b0);
      run_op("bad_alt_in_255", P256 - 1,    P256 - 1,    1'b0, 1'b1, 1'b0);
      run_op("add_5_7_again",  256'd5,      256'd7,      1'b0, 1'b1, 1'b0);
      run_op("bad_opa_eq_p",   P25519,      256'd1,      1'b0, 1'b1, 1'b0);
      run_op("good_after_bad", 256'd9,      256'd4,      1'b1, 1'b1, 1'b0);
      run_op("disturbed",      256'hABCDEF, 256'h123456, 1'b1, 1'b0, 1'b1);

      // Reset in the middle of P1: aborts at once with no done pulse.
      @(negedge clk);
      run = 1'b1; opa = 256'd100; opb = 256'd200; op_sub = 1'b0; fld_25519 = 1'b1;
      @(posedge clk);
      #1;
      run = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("midreset/res", res, 256'd0);
      check("midreset/busy", {255'b0, busy}, 256'd0);
      done_seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done) done_seen = 1'b1;
      end
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (done || busy) done_seen = 1'b1;
      end
      check("midreset/no_done", {255'b0, done_seen}, 256'd0);
      last_res = '0;
      run_op("after_reset", 256'd100, 256'd200, 1'b0, 1'b1, 1'b0);

      // Randomized cases in both fields, some with out-of-range operands.
      for (int i = 0; i < 20; i++) begin
         fld_25519 = $urandom_range(0, 1);
         p = fld_25519 ? P25519 : P256;
         a = rnd256() % p;
         b = rnd256() % p;
         if ($urandom_range(0, 7) == 0) a = p + 256'($urandom_range(0, 3));
         run_op("rand", a, b, $urandom_range(0, 1), fld_25519, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
